uart_rom_loader: RTL and testbench

- Receives a Hack program over a UART serial line and writes it into the SoC ROM through the hack_soc rom_loader interface: rom_loader_reset, rom_loader_load, rom_loader_data, rom_loader_ack and rom_loader_load_received.
- Serves as the hardware counterpart to the file-based simulation loader, for use on FPGA and silicon bring-up.
- The top level holds hack_external_reset asserted until done_loading is high.

---
 rtl/uart_rom_loader.sv | 221 ++++++++++++++++++++++
 tb/tb_uart_rom_loader.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rom_loader.sv
// UART (8N1) receiver plus loader FSM that streams a Hack program into the SoC ROM.
// Define UART_ROM_LOADER_CHECKSUM_EN to require a trailing XOR checksum byte.
module uart_rom_loader #(
    parameter int CLKS_PER_BIT = 16,
    parameter int DATA_WIDTH   = 16,
    parameter int COUNT_WIDTH  = 16
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   run,
    input  logic                   uart_rx,
    output logic                   busy,
    output logic                   done_loading,
    output logic                   error,
    output logic [COUNT_WIDTH-1:0] words_loaded,
    output logic                   rom_loader_reset,
    output logic                   rom_loader_load,
    output logic [DATA_WIDTH-1:0]  rom_loader_data,
    input  logic                   rom_loader_ack,
    input  logic                   rom_loader_load_received
);
    localparam int CNT_W = $clog2(CLKS_PER_BIT + 1);
    localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);

    typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;

    typedef enum logic [3:0] {
        IDLE, HDR_HI, HDR_LO, DATA, LOAD, WAIT_ACK,
`ifdef UART_ROM_LOADER_CHECKSUM_EN
        CHECK,
`endif
        DONE, ERROR, ABORT
    } state_t;

`ifdef UART_ROM_LOADER_CHECKSUM_EN
    localparam state_t FINAL_STATE = CHECK;
`else
    localparam state_t FINAL_STATE = DONE;
`endif

    logic             sync1_reg, sync2_reg, prev_reg;
    rx_state_t        rx_state_reg, rx_state_next;
    logic [CNT_W-1:0] tick_reg, tick_next;
    logic [2:0]       bit_reg, bit_next;
    logic [7:0]       shift_reg, shift_next;
    logic             byte_valid_reg, byte_valid_next;
    logic             frame_err_reg, frame_err_next;

    always_ff @(posedge clk) begin
        if (reset) begin
            sync1_reg      <= 1'b1;
            sync2_reg      <= 1'b1;
            prev_reg       <= 1'b1;
            rx_state_reg   <= RX_IDLE;
            tick_reg       <= '0;
            bit_reg        <= '0;
            shift_reg      <= '0;
            byte_valid_reg <= 1'b0;
            frame_err_reg  <= 1'b0;
        end else begin
            sync1_reg      <= uart_rx;
            sync2_reg      <= sync1_reg;
            prev_reg       <= sync2_reg;
            rx_state_reg   <= rx_state_next;
            tick_reg       <= tick_next;
            bit_reg        <= bit_next;
            shift_reg      <= shift_next;
            byte_valid_reg <= byte_valid_next;
            frame_err_reg  <= frame_err_next;
        end
    end

    always_comb begin
        rx_state_next   = rx_state_reg;
        tick_next       = tick_reg + CNT_W'(1);
        bit_next        = bit_reg;
        shift_next      = shift_reg;
        byte_valid_next = 1'b0;
        frame_err_next  = 1'b0;
        case (rx_state_reg)
            RX_IDLE: begin
                tick_next = '0;
                if (prev_reg && !sync2_reg) rx_state_next = RX_START;
            end
            RX_START: if (tick_reg == HALF_LAST) begin
                // A start bit that is high again at mid-bit was a glitch.
                tick_next     = '0;
                bit_next      = '0;
                rx_state_next = sync2_reg ? RX_IDLE : RX_DATA;
            end
            RX_DATA: if (tick_reg == BIT_LAST) begin
                tick_next  = '0;
                shift_next = {sync2_reg, shift_reg[7:1]};
                bit_next   = bit_reg + 3'd1;
                if (bit_reg == 3'd7) rx_state_next = RX_STOP;
            end
            default: if (tick_reg == BIT_LAST) begin
                rx_state_next   = RX_IDLE;
                byte_valid_next = sync2_reg;
                frame_err_next  = !sync2_reg;
            end
        endcase
    end

    state_t                 state_reg, state_next;
    logic [7:0]             hdr_hi_reg, hi_reg;
    logic [COUNT_WIDTH-1:0] count_reg, words_rcvd_reg, words_loaded_reg;
    logic [DATA_WIDTH-1:0]  buf_reg;
    logic                   buf_full_reg, lo_phase_reg, error_reg;
    logic                   in_check, word_phase, in_session, words_pending;
    logic                   data_byte, word_done, buf_release, overrun, last_ack, hdr_zero;
    logic [7:0]             rx_byte;

    assign rx_byte       = shift_reg;
    assign word_phase    = (state_reg inside {DATA, LOAD, WAIT_ACK}) || in_check;
    assign in_session    = word_phase || (state_reg inside {HDR_HI, HDR_LO});
    assign words_pending = (words_rcvd_reg != count_reg);
    assign data_byte     = byte_valid_reg && word_phase && words_pending;
    assign word_done     = data_byte && lo_phase_reg;
    assign buf_release   = rom_loader_ack && ((state_reg == WAIT_ACK) ||
                           (state_reg == LOAD && rom_loader_load_received));
    assign overrun       = word_done && buf_full_reg && !buf_release;
    assign last_ack      = buf_release && ((words_loaded_reg + COUNT_WIDTH'(1)) == count_reg);
    assign hdr_zero      = ({hdr_hi_reg, rx_byte} == 16'd0);

`ifdef UART_ROM_LOADER_CHECKSUM_EN
    logic [7:0] xor_reg, chk_byte_reg;
    logic       chk_got_reg;
    assign in_check = (state_reg == CHECK);
`else
    assign in_check = 1'b0;
`endif

    always_comb begin
        state_next       = state_reg;
        busy             = in_session;
        rom_loader_reset = in_session || (state_reg inside {ERROR, ABORT});
        rom_loader_load  = (state_reg == LOAD);
        rom_loader_data  = (state_reg == LOAD) ? buf_reg : '0;
        done_loading     = (state_reg == DONE);
        error            = error_reg;
        words_loaded     = words_loaded_reg;
        case (state_reg)
            IDLE:     if (run) state_next = HDR_HI;
            HDR_HI:   if (byte_valid_reg) state_next = HDR_LO;
            HDR_LO:   if (byte_valid_reg) state_next = hdr_zero ? FINAL_STATE : DATA;
            DATA:     if (buf_full_reg) state_next = LOAD;
            LOAD:     if (rom_loader_load_received)
                          state_next = rom_loader_ack ? (last_ack ? FINAL_STATE : DATA) : WAIT_ACK;
            WAIT_ACK: if (rom_loader_ack) state_next = last_ack ? FINAL_STATE : DATA;
`ifdef UART_ROM_LOADER_CHECKSUM_EN
            CHECK:    if (chk_got_reg) state_next = (chk_byte_reg == xor_reg) ? DONE : ERROR;
`endif
            DONE:     if (!run) state_next = IDLE;
            ABORT:    state_next = IDLE;
            default:  state_next = state_reg;
        endcase
        if ((in_session || state_reg == DONE) && frame_err_reg) state_next = ERROR;
        if (in_session && overrun) state_next = ERROR;
        // Dropping run wins over any fault so an aborted session never reports an error.
        if (in_session && !run) state_next = ABORT;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg        <= IDLE;
            error_reg        <= 1'b0;
            hdr_hi_reg       <= '0;
            hi_reg           <= '0;
            count_reg        <= '0;
            words_rcvd_reg   <= '0;
            words_loaded_reg <= '0;
            buf_reg          <= '0;
            buf_full_reg     <= 1'b0;
            lo_phase_reg     <= 1'b0;
`ifdef UART_ROM_LOADER_CHECKSUM_EN
            xor_reg          <= '0;
            chk_byte_reg     <= '0;
            chk_got_reg      <= 1'b0;
`endif
        end else begin
            state_reg <= state_next;
            if (state_next == ERROR) error_reg <= 1'b1;
            if (state_reg == IDLE || state_next == IDLE) begin
                words_rcvd_reg   <= '0;
                words_loaded_reg <= '0;
                buf_full_reg     <= 1'b0;
                lo_phase_reg     <= 1'b0;
`ifdef UART_ROM_LOADER_CHECKSUM_EN
                xor_reg          <= '0;
                chk_got_reg      <= 1'b0;
`endif
            end else begin
                if (state_reg == HDR_HI && byte_valid_reg) hdr_hi_reg <= rx_byte;
                if (state_reg == HDR_LO && byte_valid_reg) count_reg <= COUNT_WIDTH'({hdr_hi_reg, rx_byte});
                if (data_byte) begin
                    lo_phase_reg <= !lo_phase_reg;
                    if (!lo_phase_reg) hi_reg <= rx_byte;
                end
                if (word_done) words_rcvd_reg <= words_rcvd_reg + COUNT_WIDTH'(1);
                if (buf_release) begin
                    buf_full_reg <= 1'b0;
                    if (words_loaded_reg != count_reg)
                        words_loaded_reg <= words_loaded_reg + COUNT_WIDTH'(1);
                end
                if (word_done && (!buf_full_reg || buf_release)) begin
                    buf_reg      <= DATA_WIDTH'({hi_reg, rx_byte});
                    buf_full_reg <= 1'b1;
                end
`ifdef UART_ROM_LOADER_CHECKSUM_EN
                if (data_byte) xor_reg <= xor_reg ^ rx_byte;
                if (byte_valid_reg && word_phase && !words_pending && !chk_got_reg) begin
                    chk_byte_reg <= rx_byte;
                    chk_got_reg  <= 1'b1;
                end
`endif
            end
        end
    end
endmodule

// File: tb/tb_uart_rom_loader.sv
// Scoreboard bench for uart_rom_loader: bit-banged UART stimulus, SoC handshake model, load monitor.
module tb_uart_rom_loader;
    localparam int CPB = 16;

    logic        clk = 1'b0;
    logic        reset, run, uart_rx;
    logic        busy, done_loading, error;
    logic [15:0] words_loaded;
    logic        rom_loader_reset, rom_loader_load;
    logic [15:0] rom_loader_data;
    logic        rom_loader_ack, rom_loader_load_received;

    int          tests = 0;
    int          fails = 0;
    int          load_count = 0;
    logic [15:0] exp_q[$];
    logic        load_prev = 1'b0;
    int          ack_delay = 3;
    bit          ack_withhold = 1'b0;
    bit          same_cycle = 1'b0;

    uart_rom_loader #(.CLKS_PER_BIT(CPB), .DATA_WIDTH(16), .COUNT_WIDTH(16)) dut (
        .clk(clk), .reset(reset), .run(run), .uart_rx(uart_rx),
        .busy(busy), .done_loading(done_loading), .error(error),
        .words_loaded(words_loaded), .rom_loader_reset(rom_loader_reset),
        .rom_loader_load(rom_loader_load), .rom_loader_data(rom_loader_data),
        .rom_loader_ack(rom_loader_ack), .rom_loader_load_received(rom_loader_load_received)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
        tests++;
        if (actual !== expected) begin
            fails++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end else
            $display("[TB] ok   %s = 0x%0h", name, actual);
    endtask

    // Monitor: every new write request is checked against the scoreboard queue.
    always @(negedge clk) begin
        if (!reset && rom_loader_load && !load_prev) begin
            load_count++;
            tests++;
            if (exp_q.size() == 0) begin
                fails++;
                $display("[TB] FAIL unexpected_load: got 0x%0h, expected no write", rom_loader_data);
            end else begin
                logic [15:0] e;
                e = exp_q.pop_front();
                if (rom_loader_data !== e) begin
                    fails++;
                    $display("[TB] FAIL load_data: got 0x%0h, expected 0x%0h", rom_loader_data, e);
                end else
                    $display("[TB] ok   load_data = 0x%0h", rom_loader_data);
            end
        end
        load_prev <= reset ? 1'b0 : rom_loader_load;
    end

    // SoC model: latch on the next cycle, acknowledge ack_delay cycles later (or together).
    initial begin
        rom_loader_load_received = 1'b0;
        rom_loader_ack = 1'b0;
        forever begin
            @(negedge clk);
            if (rom_loader_load === 1'b1 && !reset) begin
                rom_loader_load_received = 1'b1;
                if (same_cycle) rom_loader_ack = 1'b1;
                @(negedge clk);
                rom_loader_load_received = 1'b0;
                rom_loader_ack = 1'b0;
                if (!same_cycle && !ack_withhold) begin
                    repeat (ack_delay - 1) @(negedge clk);
                    rom_loader_ack = 1'b1;
                    @(negedge clk);
                    rom_loader_ack = 1'b0;
                end
            end
        end
    end

    task automatic send_byte(input logic [7:0] b, input logic stop);
        uart_rx = 1'b0;
        repeat (CPB) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            uart_rx = b[i];
            repeat (CPB) @(negedge clk);
        end
        uart_rx = stop;
        repeat (CPB) @(negedge clk);
        uart_rx = 1'b1;
        repeat (CPB) @(negedge clk);
    endtask

    task automatic wait_done(input int max_cycles);
        for (int i = 0; i < max_cycles; i++) begin
            @(negedge clk);
            if (done_loading || error) break;
        end
    endtask

    task automatic do_reset();
        run = 1'b0;
        reset = 1'b1;
        repeat (3) @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic start_run();
        @(negedge clk);
        run = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic stop_run();
        @(negedge clk);
        run = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    initial begin
        int base;
        uart_rx = 1'b1;
        do_reset();
        check("rst_busy", busy, 0);
        check("rst_done", done_loading, 0);
        check("rst_error", error, 0);
        check("rst_words", words_loaded, 0);
        check("rst_romreset", rom_loader_reset, 0);
        check("rst_load", rom_loader_load, 0);
        check("rst_data", rom_loader_data, 0);

        // Two-word program, ack 3 cycles after latch.
        start_run();
        check("s1_busy", busy, 1);
        check("s1_romreset_held", rom_loader_reset, 1);
        exp_q.push_back(16'h1234);
        exp_q.push_back(16'hABCD);
        send_byte(8'h00, 1); send_byte(8'h02, 1);
        send_byte(8'h12, 1); send_byte(8'h34, 1);
        send_byte(8'hAB, 1); send_byte(8'hCD, 1);
`ifdef UART_ROM_LOADER_CHECKSUM_EN
        send_byte(8'h40, 1);
`endif
        wait_done(200);
        check("s1_done", done_loading, 1);
        check("s1_words", words_loaded, 2);
        check("s1_romreset", rom_loader_reset, 0);
        check("s1_busy_end", busy, 0);
        check("s1_error", error, 0);
        check("s1_sb_empty", exp_q.size(), 0);
        stop_run();
        check("s1_done_clr", done_loading, 0);
        check("s1_words_clr", words_loaded, 0);

        // Empty program.
        base = load_count;
        start_run();
        send_byte(8'h00, 1); send_byte(8'h00, 1);
`ifdef UART_ROM_LOADER_CHECKSUM_EN
        send_byte(8'h00, 1);
`endif
        wait_done(200);
        check("s2_done", done_loading, 1);
        check("s2_no_load", load_count - base, 0);
        check("s2_words", words_loaded, 0);
        stop_run();

        // Framing error after the header.
        base = load_count;
        start_run();
        send_byte(8'h00, 1); send_byte(8'h02, 1);
        send_byte(8'h55, 0);
        repeat (4) @(negedge clk);
        check("s3_error", error, 1);
        check("s3_load", rom_loader_load, 0);
        check("s3_busy", busy, 0);
        check("s3_romreset", rom_loader_reset, 1);
        send_byte(8'h12, 1); send_byte(8'h34, 1);
        check("s3_no_load", load_count - base, 0);
        check("s3_error_sticky", error, 1);
        do_reset();
        check("s3_error_clr", error, 0);

        // Overrun: ack withheld while the next word completes.
        base = load_count;
        ack_withhold = 1'b1;
        exp_q.push_back(16'h1111);
        start_run();
        send_byte(8'h00, 1); send_byte(8'h03, 1);
        send_byte(8'h11, 1); send_byte(8'h11, 1);
        send_byte(8'h22, 1); send_byte(8'h22, 1);
        send_byte(8'h33, 1); send_byte(8'h33, 1);
        check("s4_error", error, 1);
        check("s4_words", words_loaded, 0);
        check("s4_busy", busy, 0);
        check("s4_one_load", load_count - base, 1);
        do_reset();
        ack_withhold = 1'b0;

        // Abort after 1 of 4 words, then a full reload with same-cycle latch+ack.
        exp_q.push_back(16'h0101);
        start_run();
        send_byte(8'h00, 1); send_byte(8'h04, 1);
        send_byte(8'h01, 1); send_byte(8'h01, 1);
        for (int i = 0; i < 100 && words_loaded != 16'd1; i++) @(negedge clk);
        check("s5_words_mid", words_loaded, 1);
        @(negedge clk);
        run = 1'b0;
        @(posedge clk);
        #1;
        check("s5_abort_busy", busy, 0);
        check("s5_abort_romreset", rom_loader_reset, 1);
        @(posedge clk);
        #1;
        check("s5_idle_romreset", rom_loader_reset, 0);
        check("s5_error", error, 0);
        check("s5_done", done_loading, 0);
        same_cycle = 1'b1;
        exp_q.push_back(16'hCAFE);
        exp_q.push_back(16'hBEEF);
        start_run();
        send_byte(8'h00, 1); send_byte(8'h02, 1);
        send_byte(8'hCA, 1); send_byte(8'hFE, 1);
        send_byte(8'hBE, 1); send_byte(8'hEF, 1);
`ifdef UART_ROM_LOADER_CHECKSUM_EN
        send_byte(8'h65, 1);
`endif
        wait_done(200);
        check("s5_reload_done", done_loading, 1);
        check("s5_reload_words", words_loaded, 2);
        check("s5_sb_empty", exp_q.size(), 0);
        stop_run();
        same_cycle = 1'b0;

`ifdef UART_ROM_LOADER_CHECKSUM_EN
        exp_q.push_back(16'h1234);
        start_run();
        send_byte(8'h00, 1); send_byte(8'h01, 1);
        send_byte(8'h12, 1); send_byte(8'h34, 1);
        send_byte(8'h26, 1);
        wait_done(200);
        check("c_good_done", done_loading, 1);
        check("c_good_error", error, 0);
        stop_run();
        exp_q.push_back(16'h1234);
        start_run();
        send_byte(8'h00, 1); send_byte(8'h01, 1);
        send_byte(8'h12, 1); send_byte(8'h34, 1);
        send_byte(8'h27, 1);
        wait_done(200);
        check("c_bad_error", error, 1);
        check("c_bad_done", done_loading, 0);
        do_reset();
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
